mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: request/memory address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32: data width in bits; byte strobe width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive contended data grants before fetch is forced.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports i_req_valid input 1, i_req_ready output 1, i_addr input ADDR_W: instruction-fetch request (read only).
REQ-007 SHALL have ports i_rsp_valid output 1, i_rsp_data output DATA_W: fetch response.
REQ-008 SHALL have ports d_req_valid input 1, d_req_ready output 1, d_addr input ADDR_W, d_we input 1, d_wstrb input DATA_W/8, d_wdata input DATA_W: load/store request.
REQ-009 SHALL have ports d_rsp_valid output 1, d_rsp_data output DATA_W: load/store response.
REQ-010 SHALL have ports mem_en, mem_we output 1, mem_wstrb output DATA_W/8, mem_addr output ADDR_W, mem_wdata output DATA_W, mem_rdata input DATA_W: single-port synchronous memory, read data valid one cycle after mem_en.

Function
REQ-011 SHALL grant at most one request per cycle; grant = req_valid & req_ready, ready combinational from current valids and arbitration state.
REQ-012 SHALL, in grant cycle, drive mem_en=1 and mux winner's addr/we/wstrb/wdata onto mem_* combinationally; fetch grants force mem_we=0, mem_wstrb=0.
REQ-013 SHALL keep mem_en=0, mem_we=0 and all other mem_* outputs 0 in cycles with no grant.
REQ-014 SHALL pulse winner's rsp_valid for exactly one cycle, the cycle after grant (latency 1), rsp_data = mem_rdata for reads, 0 for writes; rsp_data SHALL be 0 when rsp_valid=0.
REQ-015 SHALL support back-to-back grants: a new grant is allowed in the same cycle a response is returned (throughput 1 access/cycle).
REQ-016 SHALL implement FSM IDLE, RESP_I, RESP_D; next state = RESP_I on fetch grant, RESP_D on data grant, else IDLE; rsp_valid decoded from state.
REQ-017 SHALL, with only one valid, grant it immediately.
REQ-018 SHALL, with both valid, grant data unless starve counter == STARVE_LIMIT, in which case grant fetch.
REQ-019 SHALL increment starve counter (saturating at STARVE_LIMIT) on each data grant while i_req_valid=1, clear it on fetch grant or whenever i_req_valid=0.
REQ-020 SHALL not back-pressure responses; requesters always accept rsp_valid.
REQ-021 SHALL treat request fields as don't-care when valid=0 and SHALL not latch request fields (requester holds them until ready).

Reset
REQ-022 SHALL, on rst=0, asynchronously force state IDLE, starve counter 0, all rsp_valid/rsp_data 0.
REQ-023 SHALL drop any outstanding response when reset asserts mid-access; no rsp_valid after release for pre-reset grants.
REQ-024 SHALL hold i_req_ready=0, d_req_ready=0 and mem_en=0 while rst=0.

Configuration
REQ-025 SHALL, with MEM_ARBITER_ROUND_ROBIN_EN defined, replace REQ-018/019 with round-robin: one-bit last-winner register (reset: fetch), contended grant goes to port not last granted; STARVE_LIMIT ignored, no starve counter.
REQ-026 SHALL, without MEM_ARBITER_ROUND_ROBIN_EN, use data-priority with starvation guard (REQ-018/019).

Verification
REQ-027 SHALL cover: fetch-only, i_addr=0x40, mem_rdata=0x0000006F next cycle -> i_req_ready=1 same cycle, i_rsp_valid=1 with 0x0000006F one cycle later.
REQ-028 SHALL cover: store d_addr=0x2000, d_wstrb=0xF, d_wdata=0xDEADBEEF -> mem_we=1, mem_wstrb=0xF same cycle; d_rsp_valid=1, d_rsp_data=0 next cycle.
REQ-029 SHALL cover: both valid continuously, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; no port starved beyond 4 cycles.
REQ-030 SHALL cover: rst=0 asserted in RESP_D cycle -> d_rsp_valid=0 immediately and after release; state IDLE.
REQ-031 SHALL cover: MEM_ARBITER_ROUND_ROBIN_EN defined, both valid continuously from reset -> grants D,I,D,I...
REQ-032 SHALL cover: alternating single requests every cycle (I,D,I) -> one grant per cycle, each response exactly one cycle after its grant to correct port.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single-port synchronous memory.
// Data has priority with a starvation guard; define MEM_ARBITER_ROUND_ROBIN_EN for round-robin.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req_valid,
  output logic                i_req_ready,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rsp_valid,
  output logic [DATA_W-1:0]   i_rsp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_wstrb,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_data,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_pick_i;
  logic   w_grant_i;
  logic   w_grant_d;
  logic   r_rsp_we;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  // 1 = data port won the most recent grant; contention goes to the other port.
  logic r_last_d;

  assign w_pick_i = r_last_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d <= 1'b0;
    end else if (w_grant_d) begin
      r_last_d <= 1'b1;
    end else if (w_grant_i) begin
      r_last_d <= 1'b0;
    end
  end
`else
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_starve;

  assign w_pick_i = (r_starve == LIMIT);

  // Counts data grants taken while fetch was waiting; any fetch grant or idle fetch clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve <= '0;
    end else if (!i_req_valid || w_grant_i) begin
      r_starve <= '0;
    end else if (w_grant_d && (r_starve != LIMIT)) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`endif

  // Grants are suppressed while reset is held so nothing reaches the memory.
  assign w_grant_i = rst && i_req_valid && (!d_req_valid || w_pick_i);
  assign w_grant_d = rst && d_req_valid && (!i_req_valid || !w_pick_i);

  assign i_req_ready = w_grant_i;
  assign d_req_ready = w_grant_d;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_grant_d) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_wstrb = d_wstrb;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_grant_i) begin
      mem_en    = 1'b1;
      mem_addr  = i_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = IDLE;
    if (w_grant_i) begin
      w_state_nxt = RESP_I;
    end else if (w_grant_d) begin
      w_state_nxt = RESP_D;
    end
  end

  // Remembers whether the in-flight data access was a store, so its response carries no data.
  always_ff @(posedge clk) begin
    if (w_grant_d) begin
      r_rsp_we <= d_we;
    end
  end

  assign i_rsp_valid = (r_state == RESP_I);
  assign d_rsp_valid = (r_state == RESP_D);
  assign i_rsp_data  = i_rsp_valid ? mem_rdata : '0;
  assign d_rsp_data  = (d_rsp_valid && !r_rsp_we) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a behavioural arbitration model.
// Honours MEM_ARBITER_ROUND_ROBIN_EN the same way the design does.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_addr;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid, d_req_ready;
  logic [AW-1:0] d_addr;
  logic          d_we;
  logic [SW-1:0] d_wstrb;
  logic [DW-1:0] d_wdata;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          mem_en, mem_we;
  logic [SW-1:0] mem_wstrb;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model: which port expects a response next cycle (0 none, 1 fetch, 2 data),
  // how many data grants in a row fetch has waited through, and who won last.
  int   m_pend    = 0;
  logic m_pend_wr = 1'b0;
  int   m_run     = 0;
  logic m_last_d  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic iv, input logic dv);
    if (iv && !dv) return 1;
    if (dv && !iv) return 2;
    if (!iv && !dv) return 0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return m_last_d ? 1 : 2;
`else
    return (m_run >= LIM) ? 1 : 2;
`endif
  endfunction

  task automatic model_reset();
    m_pend    = 0;
    m_pend_wr = 1'b0;
    m_run     = 0;
    m_last_d  = 1'b0;
  endtask

  task automatic cycle(input logic iv, input logic [AW-1:0] ia,
                       input logic dv, input logic [AW-1:0] da, input logic dwe,
                       input logic [SW-1:0] ds, input logic [DW-1:0] dwd,
                       input logic [DW-1:0] rd, output int g);
    @(negedge clk);
    i_req_valid = iv;
    i_addr      = ia;
    d_req_valid = dv;
    d_addr      = da;
    d_we        = dwe;
    d_wstrb     = ds;
    d_wdata     = dwd;
    mem_rdata   = rd;
    #1;
    g = pick(iv, dv);
    chk("i_req_ready", i_req_ready, g == 1);
    chk("d_req_ready", d_req_ready, g == 2);
    chk("mem_en", mem_en, g != 0);
    chk("mem_we", mem_we, (g == 2) && dwe);
    chk("mem_wstrb", mem_wstrb, (g == 2) ? ds : '0);
    chk("mem_addr", mem_addr, (g == 2) ? da : ((g == 1) ? ia : '0));
    chk("mem_wdata", mem_wdata, (g == 2) ? dwd : '0);
    chk("i_rsp_valid", i_rsp_valid, m_pend == 1);
    chk("i_rsp_data", i_rsp_data, (m_pend == 1) ? rd : '0);
    chk("d_rsp_valid", d_rsp_valid, m_pend == 2);
    chk("d_rsp_data", d_rsp_data, (m_pend == 2 && !m_pend_wr) ? rd : '0);
    @(posedge clk);
    m_pend    = g;
    m_pend_wr = (g == 2) && dwe;
    if (!iv || g == 1) m_run = 0;
    else if (g == 2 && m_run < LIM) m_run++;
    if (g == 1) m_last_d = 1'b0;
    if (g == 2) m_last_d = 1'b1;
  endtask

  initial begin
    int g;
    int exp_g;
    rst = 1'b0;
    i_req_valid = 1'b1; i_addr = '0;
    d_req_valid = 1'b1; d_addr = '0; d_we = 1'b0; d_wstrb = '0; d_wdata = '0;
    mem_rdata = 32'hA5A5_A5A5;
    model_reset();

    // Reset held with both requesters asking: nothing may be granted.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_i_ready", i_req_ready, 1'b0);
    chk("rst_d_ready", d_req_ready, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_i_rsp_valid", i_rsp_valid, 1'b0);
    chk("rst_d_rsp_valid", d_rsp_valid, 1'b0);
    chk("rst_d_rsp_data", d_rsp_data, 32'h0);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Fetch-only at 0x40, instruction word returned next cycle.
    cycle(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h1111_1111, g);
    chk("fetch_grant", g, 1);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0000_006F, g);

    // Full-word store; response carries no data.
    cycle(1'b0, 32'h0, 1'b1, 32'h2000, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h2222_2222, g);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h3333_3333, g);

    // Alternating single requests back to back.
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h4444_4444, g);
    cycle(1'b0, 32'h0, 1'b1, 32'h3000, 1'b0, 4'h3, 32'h55, 32'h5555_5555, g);
    cycle(1'b1, 32'h104, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h6666_6666, g);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h7777_7777, g);

    // Reset asserted while a load response is due.
    cycle(1'b0, 32'h0, 1'b1, 32'h3004, 1'b0, 4'h0, 32'h0, 32'h8888_8888, g);
    #1;
    rst = 1'b0;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    mem_rdata = 32'h1234_5678;
    #1;
    model_reset();
    chk("midrst_d_rsp_valid", d_rsp_valid, 1'b0);
    chk("midrst_d_rsp_data", d_rsp_data, 32'h0);
    chk("midrst_d_ready", d_req_ready, 1'b0);
    chk("midrst_i_ready", i_req_ready, 1'b0);
    chk("midrst_mem_en", mem_en, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_hold_d_rsp_valid", d_rsp_valid, 1'b0);
    chk("midrst_hold_mem_en", mem_en, 1'b0);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h9999_9999, g);

    // Both ports requesting continuously straight out of reset.
    for (int k = 0; k < 15; k++) begin
      cycle(1'b1, 32'h200 + 32'(4 * k), 1'b1, 32'h4000 + 32'(4 * k), 1'b0, 4'h0, 32'h0,
            $urandom, g);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      exp_g = (k % 2 == 0) ? 2 : 1;
`else
      exp_g = (k % 5 == 4) ? 1 : 2;
`endif
      chk($sformatf("contend_pattern_%0d", k), g, exp_g);
    end

    // Randomized traffic, busy on both ports most of the time.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
            4'($urandom), $urandom, $urandom, g);
    end
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, $urandom, g);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
